// File: rtl/mult_pkg.sv
// Shared types for the iterative multiplier: sequencer states and CPSR flag positions
// (the flag positions are also used by the ALU).
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mult_state_e;

   localparam int unsigned FLAG_N = 31;
   localparam int unsigned FLAG_Z = 30;
   localparam int unsigned FLAG_C = 29;
   localparam int unsigned FLAG_V = 28;

endpackage

// File: rtl/mult_step.sv
// One radix-4 shift-add step: adds 0, 1, 2 or 3 times the multiplicand to the accumulator.
module mult_step #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] acc,
   input  logic [1:0]   bits,
   input  logic [W-1:0] mcand,
   output logic [W-1:0] acc_nxt_c
);

   always_comb begin
      acc_nxt_c = acc;
      if (bits[0]) acc_nxt_c = acc_nxt_c + mcand;
      if (bits[1]) acc_nxt_c = acc_nxt_c + (mcand << 1);
   end

endmodule

// File: rtl/mult_seq.sv
// MUL/MLA sequencer: 2 multiplier bits per cycle with early termination on an exhausted multiplier.
// Define MULT_SEQ_LONG_EN to add 64-bit UMULL/SMULL/UMLAL/SMLAL support.
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             flush,
   input  logic             acc_en,
   input  logic             set_flags,
   input  logic [3:0]       rd,
   input  logic [WIDTH-1:0] rm,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] cpsr_in,
`ifdef MULT_SEQ_LONG_EN
   input  logic             long_en,
   input  logic             signed_en,
   input  logic [WIDTH-1:0] acc_hi_in,
   input  logic [3:0]       rd_hi,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       result_rd_hi,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       result_rd,
   output logic [WIDTH-1:0] cpsr_out
);

`ifdef MULT_SEQ_LONG_EN
   localparam int unsigned AW = 2 * WIDTH;
`else
   localparam int unsigned AW = WIDTH;
`endif

   mult_state_e      state_q, state_d;
   logic [WIDTH-1:0] bitfield_q, bitfield_d;
   logic [AW-1:0]    mcand_q, mcand_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    step_acc_c;
   logic [3:0]       rd_q, rd_d;
   logic             s_q, s_d;
   logic [WIDTH-1:0] cpsr_q, cpsr_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       result_rd_q, result_rd_d;
   logic [WIDTH-1:0] cpsr_out_q, cpsr_out_d;
   logic             res_n_c, res_z_c;
`ifdef MULT_SEQ_LONG_EN
   logic             long_q, long_d;
   logic [3:0]       rd_hi_q, rd_hi_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic [3:0]       result_rd_hi_q, result_rd_hi_d;
`endif

   mult_step #(.W(AW)) u_step (
      .acc       (acc_q),
      .bits      (bitfield_q[1:0]),
      .mcand     (mcand_q),
      .acc_nxt_c (step_acc_c)
   );

   // Next-state, datapath updates and stall request
   always_comb begin
      state_d     = state_q;
      bitfield_d  = bitfield_q;
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      rd_d        = rd_q;
      s_d         = s_q;
      cpsr_d      = cpsr_q;
      done_d      = 1'b0;
      result_d    = result_q;
      result_rd_d = result_rd_q;
      cpsr_out_d  = cpsr_out_q;
      res_n_c     = acc_q[WIDTH-1];
      res_z_c     = (acc_q[WIDTH-1:0] == '0);
      busy        = 1'b0;
`ifdef MULT_SEQ_LONG_EN
      long_d         = long_q;
      rd_hi_d        = rd_hi_q;
      result_hi_d    = result_hi_q;
      result_rd_hi_d = result_rd_hi_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req && !flush) begin
               busy       = 1'b1;
               state_d    = ST_RUN;
               bitfield_d = rm;
               rd_d       = rd;
               s_d        = set_flags;
               cpsr_d     = cpsr_in;
`ifdef MULT_SEQ_LONG_EN
               long_d  = long_en;
               rd_hi_d = rd_hi;
               if (long_en) begin
                  mcand_d = signed_en ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
                  // A negative signed multiplier is walked as unsigned; subtract rs*2^32 to correct
                  acc_d   = (acc_en ? {acc_hi_in, acc_in} : '0)
                          - ((signed_en && rm[WIDTH-1]) ? {rs, {WIDTH{1'b0}}} : '0);
               end else begin
                  mcand_d = {{WIDTH{1'b0}}, rs};
                  acc_d   = acc_en ? {{WIDTH{1'b0}}, acc_in} : '0;
               end
`else
               mcand_d = rs;
               acc_d   = acc_en ? acc_in : '0;
`endif
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else if (bitfield_q != '0) begin
               acc_d      = step_acc_c;
               bitfield_d = bitfield_q >> 2;
               mcand_d    = mcand_q << 2;
            end else begin
               result_d    = acc_q[WIDTH-1:0];
               result_rd_d = rd_q;
`ifdef MULT_SEQ_LONG_EN
               if (long_q) begin
                  result_hi_d    = acc_q[AW-1:WIDTH];
                  result_rd_hi_d = rd_hi_q;
                  res_n_c        = acc_q[AW-1];
                  res_z_c        = (acc_q == '0);
               end
`endif
               cpsr_out_d = cpsr_q;
               if (s_q) begin
                  cpsr_out_d[FLAG_N] = res_n_c;
                  cpsr_out_d[FLAG_Z] = res_z_c;
                  cpsr_out_d[FLAG_C] = 1'b0;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = !flush;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bitfield_q  <= '0;
         mcand_q     <= '0;
         acc_q       <= '0;
         rd_q        <= '0;
         s_q         <= 1'b0;
         cpsr_q      <= '0;
         done_q      <= 1'b0;
         result_q    <= '0;
         result_rd_q <= '0;
         cpsr_out_q  <= '0;
`ifdef MULT_SEQ_LONG_EN
         long_q         <= 1'b0;
         rd_hi_q        <= '0;
         result_hi_q    <= '0;
         result_rd_hi_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bitfield_q  <= bitfield_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         rd_q        <= rd_d;
         s_q         <= s_d;
         cpsr_q      <= cpsr_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_rd_q <= result_rd_d;
         cpsr_out_q  <= cpsr_out_d;
`ifdef MULT_SEQ_LONG_EN
         long_q         <= long_d;
         rd_hi_q        <= rd_hi_d;
         result_hi_q    <= result_hi_d;
         result_rd_hi_q <= result_rd_hi_d;
`endif
      end
   end

   assign done      = done_q;
   assign result    = result_q;
   assign result_rd = result_rd_q;
   assign cpsr_out  = cpsr_out_q;
`ifdef MULT_SEQ_LONG_EN
   assign result_hi    = result_hi_q;
   assign result_rd_hi = result_rd_hi_q;
`endif

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases plus random operands against an
// arithmetic reference model (product, latency from multiplier bit length, flags).
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        rst, req, flush, acc_en, set_flags;
   logic [3:0]  rd;
   logic [31:0] rm, rs, acc_in, cpsr_in;
   logic        busy, done;
   logic [31:0] result, cpsr_out;
   logic [3:0]  result_rd;
`ifdef MULT_SEQ_LONG_EN
   logic        long_en, signed_en;
   logic [31:0] acc_hi_in, result_hi;
   logic [3:0]  rd_hi, result_rd_hi;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .flush        (flush),
      .acc_en       (acc_en),
      .set_flags    (set_flags),
      .rd           (rd),
      .rm           (rm),
      .rs           (rs),
      .acc_in       (acc_in),
      .cpsr_in      (cpsr_in),
`ifdef MULT_SEQ_LONG_EN
      .long_en      (long_en),
      .signed_en    (signed_en),
      .acc_hi_in    (acc_hi_in),
      .rd_hi        (rd_hi),
      .result_hi    (result_hi),
      .result_rd_hi (result_rd_hi),
`endif
      .busy         (busy),
      .done         (done),
      .result       (result),
      .result_rd    (result_rd),
      .cpsr_out     (cpsr_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from the accepting edge to done: two bits of multiplier per cycle, plus two
   function automatic int exp_latency(input logic [31:0] m);
      int k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      return (k + 1) / 2 + 2;
   endfunction

   function automatic logic [31:0] exp_flags(input logic [31:0] res, input logic s,
                                              input logic [31:0] cpsr);
      if (!s) return cpsr;
      return {res[31], (res == 32'd0), 1'b0, cpsr[28:0]};
   endfunction

   // Called right after the accepting edge; drops req once the stall ends
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (!done && cyc < 40) begin
         if (busy) bcnt++;
         else req = 1'b0;
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a_rm, input logic [31:0] a_rs,
                         input logic [31:0] a_acc, input logic a_en, input logic a_s,
                         input logic [3:0] a_rd, input logic [31:0] a_cpsr);
      int cyc, bcnt, lat;
      logic [31:0] exp_res;
      rm = a_rm; rs = a_rs; acc_in = a_acc; acc_en = a_en; set_flags = a_s;
      rd = a_rd; cpsr_in = a_cpsr; req = 1'b1;
      #1;
      check({tag, ".busy_req"}, 64'(busy), 64'd1);
      tick();
      wait_done(cyc, bcnt);
      lat     = exp_latency(a_rm);
      exp_res = a_rm * a_rs + (a_en ? a_acc : 32'd0);
      check({tag, ".latency"}, 64'(cyc), 64'(lat));
      check({tag, ".busy_cycles"}, 64'(bcnt), 64'(lat - 1));
      check({tag, ".result"}, 64'(result), 64'(exp_res));
      check({tag, ".rd"}, 64'(result_rd), 64'(a_rd));
      check({tag, ".cpsr"}, 64'(cpsr_out), 64'(exp_flags(exp_res, a_s, a_cpsr)));
      req = 1'b0;
      tick();
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic no_done_for(input string tag, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] r_rm, r_rs, r_acc, r_cpsr;
      int c;
      rst = 1'b1; req = 1'b0; flush = 1'b0; acc_en = 1'b0; set_flags = 1'b0;
      rd = 4'd0; rm = 32'd0; rs = 32'd0; acc_in = 32'd0; cpsr_in = 32'd0;
`ifdef MULT_SEQ_LONG_EN
      long_en = 1'b0; signed_en = 1'b0; acc_hi_in = 32'd0; rd_hi = 4'd0;
`endif
      tick(); tick();
      check("reset.done", 64'(done), 64'd0);
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.result", 64'(result), 64'd0);
      check("reset.rd", 64'(result_rd), 64'd0);
      check("reset.cpsr", 64'(cpsr_out), 64'd0);
      rst = 1'b0;
      tick();

      run_op("mul3x5", 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd2, 32'h0000_0000);
      run_op("zero_rm", 32'd0, 32'd1234, 32'd0, 1'b0, 1'b1, 4'd9, 32'h8000_0000);
      run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 4'd7, 32'h3000_0010);
      check("all_ones.const_cpsr", 64'(cpsr_out), 64'h1000_0010);

      // Flush during the third RUN cycle: nothing completes and outputs hold
      rm = 32'h00FF_0000; rs = 32'd11; acc_en = 1'b0; set_flags = 1'b1; rd = 4'd3; req = 1'b1;
      tick(); tick(); tick();
      flush = 1'b1; req = 1'b0;
      tick();
      check("flush_run.idle", 64'(busy), 64'd0);
      check("flush_run.done", 64'(done), 64'd0);
      flush = 1'b0;
      no_done_for("flush_run.no_done", 20);
      check("flush_run.result_hold", 64'(result), 64'd3);
      check("flush_run.rd_hold", 64'(result_rd), 64'd7);
      check("flush_run.cpsr_hold", 64'(cpsr_out), 64'h1000_0010);
      run_op("after_flush", 32'd2, 32'd7, 32'd0, 1'b0, 1'b0, 4'd5, 32'd0);
      check("after_flush.const", 64'(result), 64'd14);

      // req and flush together in IDLE must not start anything
      rm = 32'd3; rs = 32'd5; req = 1'b1; flush = 1'b1;
      #1;
      check("req_flush.busy", 64'(busy), 64'd0);
      tick();
      req = 1'b0; flush = 1'b0;
      #1;
      check("req_flush.not_run", 64'(busy), 64'd0);
      no_done_for("req_flush.no_done", 10);

      // Flush while in DONE gates the pulse
      rm = 32'd5; rs = 32'd9; req = 1'b1;
      tick();
      c = 0;
      while (busy && c < 40) begin tick(); c++; end
      check("flush_done.reached", 64'(c < 40), 64'd1);
      req = 1'b0; flush = 1'b1;
      tick();
      check("flush_done.gated", 64'(done), 64'd0);
      flush = 1'b0;
      no_done_for("flush_done.no_done", 5);

      // Reset mid-operation clears outputs and abandons the op
      rm = 32'h0000_FFFF; rs = 32'd3; req = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1; req = 1'b0;
      tick();
      check("rst_run.done", 64'(done), 64'd0);
      check("rst_run.busy", 64'(busy), 64'd0);
      check("rst_run.result", 64'(result), 64'd0);
      check("rst_run.rd", 64'(result_rd), 64'd0);
      check("rst_run.cpsr", 64'(cpsr_out), 64'd0);
      rst = 1'b0;
      no_done_for("rst_run.no_done", 20);

      for (int i = 0; i < 40; i++) begin
         int sh;
         sh     = $urandom_range(0, 32);
         r_rm   = (sh == 32) ? 32'd0 : ($urandom >> sh);
         r_rs   = $urandom;
         r_acc  = $urandom;
         r_cpsr = $urandom;
         run_op($sformatf("rand%0d", i), r_rm, r_rs, r_acc, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), r_cpsr);
      end

`ifdef MULT_SEQ_LONG_EN
      for (int j = 0; j < 2; j++) begin
         int cyc, bcnt;
         longint exp64;
         long_en = 1'b1; signed_en = (j == 0); acc_en = 1'b0; set_flags = 1'b1;
         rm = 32'hFFFF_FFFF; rs = 32'd3; rd = 4'd1; rd_hi = 4'd2; cpsr_in = 32'd0; req = 1'b1;
         exp64 = (j == 0) ? -64'sd3 : 64'h0000_0002_FFFF_FFFD;
         tick();
         wait_done(cyc, bcnt);
         check($sformatf("long%0d.latency", j), 64'(cyc), 64'd18);
         check($sformatf("long%0d.product", j), {result_hi, result}, 64'(exp64));
         check($sformatf("long%0d.rd_hi", j), 64'(result_rd_hi), 64'd2);
         check($sformatf("long%0d.n", j), 64'(cpsr_out[31]), 64'(exp64[63]));
         req = 1'b0; long_en = 1'b0; signed_en = 1'b0;
         tick();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
